rect_sum_engine: RTL and testbench
==================================

RECT_SUM_ENGINE -- requirements
Module: rect_sum_engine

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 4: integral-image columns.
REQ-002 SHALL have parameter IMG_HEIGHT, default 4: integral-image rows.
REQ-003 SHALL have parameter INT_W, default 16: signed integral-word width.
REQ-004 SHALL have parameter ADDR_W, default 8: integral M10K address width.
REQ-005 SHALL have a single clock and a synchronous, active-high reset.
REQ-006 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-008 SHALL have port req_valid, input, 1 bit: rectangle request present.
REQ-009 SHALL have port req_ready, output, 1 bit: engine accepts a request.
REQ-010 SHALL have ports req_x0, req_x1, inputs, clog2(IMG_WIDTH) bits each: inclusive column bounds.
REQ-011 SHALL have ports req_y0, req_y1, inputs, clog2(IMG_HEIGHT) bits each: inclusive row bounds.
REQ-012 SHALL have port M10K_read_address_int, output, ADDR_W bits: integral M10K read address.
REQ-013 SHALL have port M10K_read_data_int, input, signed INT_W bits: integral M10K read data.
REQ-014 SHALL have port sum_valid, output, 1 bit: result available.
REQ-015 SHALL have port sum_ready, input, 1 bit: consumer takes the result.
REQ-016 SHALL have port sum_data, output, signed INT_W+2 bits: rectangle sum.
REQ-017 SHALL have port sum_err, output, 1 bit: request rejected (see Configuration).

Function
REQ-018 SHALL accept a request on the rising edge where req_valid && req_ready (cycle N), latching all four bounds.
REQ-019 SHALL use FSM states IDLE -> ISSUE (4 cycles) -> DRAIN (2 cycles) -> HOLD -> IDLE; req_ready=1 only in IDLE.
REQ-020 SHALL present corner addresses in cycles N+1..N+4, in the order D(x1,y1), B(x1,y0-1), C(x0-1,y1), A(x0-1,y0-1); address = y*IMG_WIDTH + x.
REQ-021 SHALL sample read data 2 cycles after its address is presented (cycles N+3..N+6), matching the M10K read latency.
REQ-022 SHALL compute sum = D - B - C + A in INT_W+2-bit signed arithmetic with sign extension and no saturation.
REQ-023 SHALL treat a corner with x0==0 or y0==0 (B, C or A as applicable) as zero while still consuming its issue slot; the address for that slot is 0.
REQ-024 SHALL assert sum_valid from cycle N+7, holding sum_data and sum_err stable until sum_ready is sampled high.
REQ-025 SHALL return to IDLE in the cycle after the sum_valid && sum_ready handshake, giving req_ready=1 no earlier than N+8.
REQ-026 SHALL treat a request with x0==x1 and y0==y1 as a single-pixel sum.
REQ-027 SHALL produce a full-image sum, with only D read non-zero, for the request (0,0)-(W-1,H-1).
REQ-028 SHALL ignore req_valid outside IDLE; bounds SHALL NOT change while the engine is busy.

Reset
REQ-029 SHALL, on reset, enter IDLE; req_ready=1 in the first cycle after reset deasserts.
REQ-030 SHALL, on reset, clear sum_valid, sum_err and sum_data to 0 and M10K_read_address_int to 0.
REQ-031 SHALL, on reset in any state, abandon the in-flight request and discard pending read data.

Configuration
REQ-032 SHALL, with RECT_SUM_BOUNDS_EN defined, flag as an error any request with x0>x1, y0>y1, x1>=IMG_WIDTH or y1>=IMG_HEIGHT.
REQ-033 SHALL, for an error request under RECT_SUM_BOUNDS_EN, skip ISSUE/DRAIN, assert sum_valid at N+1 with sum_data=0 and sum_err=1.
REQ-034 SHALL, without RECT_SUM_BOUNDS_EN, tie sum_err to 0 and perform no check; results for illegal bounds are unspecified.

Structure
REQ-035 SHALL place the FSM state enum, default widths and the corner-order constants in the shared package rect_sum_pkg.
REQ-036 SHALL implement corner-coordinate selection, zero-masking and address computation in one sub-module, rect_corner_addr.

Verification
REQ-037 SHALL cover: 4x4 integral image of an all-ones source; request (1,1)-(2,2) -> sum_data=4 at N+7.
REQ-038 SHALL cover: request (0,0)-(3,3) on an all-ones image -> sum_data=16; slots B, C and A masked to zero.
REQ-039 SHALL cover: source value -5 at pixel (2,1), all others 0; request (2,1)-(2,1) -> sum_data=-5.
REQ-040 SHALL cover: sum_ready held low 10 cycles -> sum_valid and sum_data stable, req_ready=0 throughout.
REQ-041 SHALL cover: reset asserted at N+4 -> sum_valid never rises; req_ready=1 the cycle after reset.
REQ-042 SHALL cover: under RECT_SUM_BOUNDS_EN, request x0=3, x1=1 -> sum_err=1, sum_data=0 at N+1.

Source files
------------

// File: rtl/rect_sum_pkg.sv
// Shared types and constants for the rectangle-sum engine: FSM state
// encoding, default widths, phase lengths and the corner issue order.
package rect_sum_pkg;

  localparam int DEF_IMG_WIDTH  = 4;
  localparam int DEF_IMG_HEIGHT = 4;
  localparam int DEF_INT_W      = 16;
  localparam int DEF_ADDR_W     = 8;

  // Cycles spent presenting corner addresses and waiting for the last read.
  localparam int ISSUE_CYCLES = 4;
  localparam int DRAIN_CYCLES = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  // Corner slot index; the numeric order is the order corners are issued.
  typedef logic [1:0] corner_t;
  localparam corner_t CORNER_D = 2'd0;  // (x1,   y1)
  localparam corner_t CORNER_B = 2'd1;  // (x1,   y0-1)
  localparam corner_t CORNER_C = 2'd2;  // (x0-1, y1)
  localparam corner_t CORNER_A = 2'd3;  // (x0-1, y0-1)

  // B and C are subtracted from the sum, D and A are added.
  function automatic logic corner_negated(input corner_t c);
    return (c == CORNER_B) || (c == CORNER_C);
  endfunction

endpackage

// File: rtl/rect_corner_addr.sv
// Corner coordinate selection, zero-masking and integral-image address
// generation for one corner slot of a rectangle request.
module rect_corner_addr
  import rect_sum_pkg::*;
#(
  parameter int IMG_WIDTH = DEF_IMG_WIDTH,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int XW        = 2,
  parameter int YW        = 2
) (
  input  corner_t             i_slot,
  input  logic [XW-1:0]       i_x0,
  input  logic [XW-1:0]       i_x1,
  input  logic [YW-1:0]       i_y0,
  input  logic [YW-1:0]       i_y1,
  output logic [ADDR_W-1:0]   o_addr,
  output logic                o_zero
);

  logic          w_use_x1;
  logic          w_use_y1;
  logic [XW-1:0] w_x;
  logic [YW-1:0] w_y;

  // A corner left of column 0 or above row 0 lies outside the integral image
  // and contributes zero; its slot still issues, at address 0.
  always_comb begin
    w_use_x1 = (i_slot == CORNER_D) || (i_slot == CORNER_B);
    w_use_y1 = (i_slot == CORNER_D) || (i_slot == CORNER_C);
    w_x      = w_use_x1 ? i_x1 : (i_x0 - XW'(1));
    w_y      = w_use_y1 ? i_y1 : (i_y0 - YW'(1));
    o_zero   = (!w_use_x1 && (i_x0 == '0)) || (!w_use_y1 && (i_y0 == '0));
    o_addr   = o_zero ? '0
                      : (ADDR_W'(w_y) * ADDR_W'(IMG_WIDTH) + ADDR_W'(w_x));
  end

endmodule

// File: rtl/rect_sum_engine.sv
// Rectangle-sum engine: reads four corners of an integral image from an
// M10K with 2-cycle read latency and returns D - B - C + A.
// Optional feature macro: RECT_SUM_BOUNDS_EN (reject illegal bounds with
// sum_err=1, sum_data=0 one cycle after acceptance).
module rect_sum_engine
  import rect_sum_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int INT_W      = DEF_INT_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1,
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [XW-1:0]            req_x0,
  input  logic [XW-1:0]            req_x1,
  input  logic [YW-1:0]            req_y0,
  input  logic [YW-1:0]            req_y1,
  output logic [ADDR_W-1:0]        M10K_read_address_int,
  input  logic signed [INT_W-1:0]  M10K_read_data_int,
  output logic                     sum_valid,
  input  logic                     sum_ready,
  output logic signed [INT_W+1:0]  sum_data,
  output logic                     sum_err
);

  localparam int SUM_W = INT_W + 2;

  state_t                   r_state;
  state_t                   w_state_nxt;
  corner_t                  r_slot;
  logic [XW-1:0]            r_x0, r_x1;
  logic [YW-1:0]            r_y0, r_y1;
  logic                     w_accept;
  logic                     w_bad;
  logic [ADDR_W-1:0]        w_addr;
  logic                     w_zero;
  logic                     r_vld_p1, r_vld_p2;
  logic                     r_zero_p1, r_zero_p2;
  corner_t                  r_slot_p1, r_slot_p2;
  logic signed [SUM_W-1:0]  w_term;
  logic signed [SUM_W-1:0]  r_acc;
  logic                     r_sum_valid;
  logic signed [SUM_W-1:0]  r_sum_data;

  // Sign-extend one corner word and apply its mask and sign.
  function automatic logic signed [SUM_W-1:0] corner_term(
    input logic signed [INT_W-1:0] d,
    input logic                    zero,
    input logic                    neg
  );
    logic signed [SUM_W-1:0] ext;
    ext = SUM_W'(d);
    if (zero) return '0;
    return neg ? -ext : ext;
  endfunction

  assign req_ready = (r_state == S_IDLE);
  assign w_accept  = req_valid && req_ready;

`ifdef RECT_SUM_BOUNDS_EN
  logic r_sum_err;
  assign w_bad = (req_x0 > req_x1) || (req_y0 > req_y1) ||
                 (32'(req_x1) >= IMG_WIDTH) || (32'(req_y1) >= IMG_HEIGHT);
  assign sum_err = r_sum_err;

  // Error flag is set only by a rejected request and cleared on handshake.
  always_ff @(posedge clk) begin
    if (reset)                          r_sum_err <= 1'b0;
    else if (w_accept)                  r_sum_err <= w_bad;
    else if (r_sum_valid && sum_ready)  r_sum_err <= 1'b0;
  end
`else
  assign w_bad   = 1'b0;
  assign sum_err = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state: fixed-length ISSUE and DRAIN, HOLD until the result is taken.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_bad ? S_HOLD : S_ISSUE;
      S_ISSUE: if (r_slot == corner_t'(ISSUE_CYCLES - 1)) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_slot == corner_t'(DRAIN_CYCLES - 1)) w_state_nxt = S_HOLD;
      S_HOLD:  if (sum_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Phase counter: restarts on every state change, doubles as the corner slot.
  always_ff @(posedge clk) begin
    if (reset)                      r_slot <= '0;
    else if (w_state_nxt != r_state) r_slot <= '0;
    else                            r_slot <= r_slot + corner_t'(1);
  end

  // Bounds are captured only on acceptance, so they stay fixed while busy.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_x0 <= req_x0;
      r_x1 <= req_x1;
      r_y0 <= req_y0;
      r_y1 <= req_y1;
    end
  end

  // ---- stage p0: corner address presented to the M10K ----
  rect_corner_addr #(
    .IMG_WIDTH (IMG_WIDTH),
    .ADDR_W    (ADDR_W),
    .XW        (XW),
    .YW        (YW)
  ) u_corner (
    .i_slot (r_slot),
    .i_x0   (r_x0),
    .i_x1   (r_x1),
    .i_y0   (r_y0),
    .i_y1   (r_y1),
    .o_addr (w_addr),
    .o_zero (w_zero)
  );

  assign M10K_read_address_int = (r_state == S_ISSUE) ? w_addr : '0;

  // ---- stages p1/p2: slot tags follow the read through the M10K latency ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      r_vld_p1 <= (r_state == S_ISSUE);
      r_vld_p2 <= r_vld_p1;
    end
  end

  // Slot identity and mask ride alongside the valid bits.
  always_ff @(posedge clk) begin
    r_zero_p1 <= w_zero;
    r_slot_p1 <= r_slot;
    r_zero_p2 <= r_zero_p1;
    r_slot_p2 <= r_slot_p1;
  end

  // ---- stage p2: read data returns and is accumulated ----
  assign w_term = corner_term(M10K_read_data_int, r_zero_p2,
                              corner_negated(r_slot_p2));

  // Accumulator restarts on corner D, the first data to return.
  always_ff @(posedge clk) begin
    if (r_vld_p2) r_acc <= (r_slot_p2 == CORNER_D) ? w_term : (r_acc + w_term);
  end

  // Result register: loaded on the last corner or a rejected request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum_valid <= 1'b0;
      r_sum_data  <= '0;
    end else if (w_accept && w_bad) begin
      r_sum_valid <= 1'b1;
      r_sum_data  <= '0;
    end else if (r_vld_p2 && (r_slot_p2 == CORNER_A)) begin
      r_sum_valid <= 1'b1;
      r_sum_data  <= r_acc + w_term;
    end else if (r_sum_valid && sum_ready) begin
      r_sum_valid <= 1'b0;
    end
  end

  assign sum_valid = r_sum_valid;
  assign sum_data  = r_sum_data;

endmodule

// File: tb/tb_rect_sum_engine.sv
// Self-checking bench for rect_sum_engine: M10K model with 2-cycle read
// latency, integral image built from a source image, and rectangle sums
// checked against a direct pixel sum over the requested region.
module tb_rect_sum_engine;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int IW = 16;
  localparam int AW = 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_x0, req_x1, req_y0, req_y1;
  logic [AW-1:0]         M10K_read_address_int;
  logic signed [IW-1:0]  M10K_read_data_int;
  logic                  sum_valid;
  logic                  sum_ready;
  logic signed [IW+1:0]  sum_data;
  logic                  sum_err;

  int total = 0;
  int bad   = 0;

  int                   src [H][W];
  logic signed [IW-1:0] mem [256];
  logic [AW-1:0]        r_a1;

  always #5 clk = ~clk;

  rect_sum_engine #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .INT_W     (IW),
    .ADDR_W    (AW)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .req_valid             (req_valid),
    .req_ready             (req_ready),
    .req_x0                (req_x0),
    .req_x1                (req_x1),
    .req_y0                (req_y0),
    .req_y1                (req_y1),
    .M10K_read_address_int (M10K_read_address_int),
    .M10K_read_data_int    (M10K_read_data_int),
    .sum_valid             (sum_valid),
    .sum_ready             (sum_ready),
    .sum_data              (sum_data),
    .sum_err               (sum_err)
  );

  // M10K: registered address, registered data -> 2-cycle read latency.
  always @(posedge clk) begin
    r_a1               <= M10K_read_address_int;
    M10K_read_data_int <= mem[r_a1];
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Integral image: each entry is the sum of all source pixels above-left.
  task automatic build_integral();
    for (int i = 0; i < 256; i++) mem[i] = '0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        int s;
        s = 0;
        for (int yy = 0; yy <= y; yy++)
          for (int xx = 0; xx <= x; xx++) s += src[yy][xx];
        mem[y*W + x] = IW'(s);
      end
  endtask

  task automatic fill_const(input int v);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) src[y][x] = v;
    build_integral();
  endtask

  task automatic fill_random();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) src[y][x] = int'($urandom_range(0, 4000)) - 2000;
    build_integral();
  endtask

  function automatic longint ref_sum(input int x0, x1, y0, y1);
    longint s;
    s = 0;
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) s += src[y][x];
    return s;
  endfunction

  // Expected address for issue slot k: D, B, C, A; off-image corners read 0.
  function automatic int exp_addr(input int k, x0, x1, y0, y1);
    int cx, cy;
    cx = (k == 0 || k == 1) ? x1 : x0 - 1;
    cy = (k == 0 || k == 2) ? y1 : y0 - 1;
    if (cx < 0 || cy < 0) return 0;
    return cy*W + cx;
  endfunction

  task automatic run_req(input int x0, x1, y0, y1, input int hold, input bit is_bad);
    longint exp_sum;
    int     lat;
    bit     seen;
    exp_sum = is_bad ? 0 : ref_sum(x0, x1, y0, y1);
    @(negedge clk);
    chk("ready_before_req", req_ready, 1);
    req_valid = 1'b1;
    req_x0 = 2'(x0); req_x1 = 2'(x1); req_y0 = 2'(y0); req_y1 = 2'(y1);
    lat  = 0;
    seen = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      // Junk requests while busy must be ignored.
      req_valid = 1'($urandom);
      req_x0 = 2'($urandom); req_x1 = 2'($urandom);
      req_y0 = 2'($urandom); req_y1 = 2'($urandom);
      if (!is_bad && k <= 4)
        chk($sformatf("addr_slot%0d", k-1), M10K_read_address_int,
            exp_addr(k-1, x0, x1, y0, y1));
      if (sum_valid) begin
        seen = 1'b1;
        lat  = k;
      end else begin
        chk("ready_busy", req_ready, 0);
      end
    end
    chk("latency", lat, is_bad ? 1 : 7);
    chk("sum_data", sum_data, exp_sum);
    chk("sum_err", sum_err, is_bad ? 1 : 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      req_valid = 1'($urandom);
      chk("hold_valid", sum_valid, 1);
      chk("hold_data", sum_data, exp_sum);
      chk("hold_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    sum_ready = 1'b1;
    @(negedge clk);
    sum_ready = 1'b0;
    chk("ready_after_take", req_ready, 1);
    chk("valid_after_take", sum_valid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    sum_ready = 1'b0;
    req_x0 = '0; req_x1 = '0; req_y0 = '0; req_y1 = '0;
    fill_const(0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_valid", sum_valid, 0);
    chk("rst_err", sum_err, 0);
    chk("rst_data", sum_data, 0);
    chk("rst_addr", M10K_read_address_int, 0);

    // All-ones source image.
    fill_const(1);
    run_req(1, 2, 1, 2, 0, 1'b0);
    run_req(0, 3, 0, 3, 0, 1'b0);
    run_req(2, 3, 0, 1, 1, 1'b0);

    // Single negative pixel.
    fill_const(0);
    src[1][2] = -5;
    build_integral();
    run_req(2, 2, 1, 1, 0, 1'b0);
    run_req(0, 3, 0, 3, 0, 1'b0);

    // Consumer stalls for 10 cycles.
    fill_random();
    run_req(1, 3, 0, 2, 10, 1'b0);

    // Reset while a request is in flight.
    begin
      bit rose;
      @(negedge clk);
      req_valid = 1'b1;
      req_x0 = 2'd0; req_x1 = 2'd3; req_y0 = 2'd0; req_y1 = 2'd3;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_valid", sum_valid, 0);
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_ready", req_ready, 1);
      chk("midrst_addr", M10K_read_address_int, 0);
      rose = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (sum_valid) rose = 1'b1;
      end
      chk("midrst_no_valid", rose, 0);
      run_req(1, 2, 1, 3, 0, 1'b0);
    end

`ifdef RECT_SUM_BOUNDS_EN
    run_req(3, 1, 0, 2, 2, 1'b1);
    run_req(0, 2, 3, 1, 0, 1'b1);
`endif

    // Randomized legal (and, with the check enabled, some illegal) requests.
    for (int t = 0; t < 30; t++) begin
      int x0, x1, y0, y1;
      bit make_bad;
      if (t % 6 == 0) fill_random();
      x0 = int'($urandom_range(0, W-1));
      x1 = int'($urandom_range(x0, W-1));
      y0 = int'($urandom_range(0, H-1));
      y1 = int'($urandom_range(y0, H-1));
      make_bad = 1'b0;
`ifdef RECT_SUM_BOUNDS_EN
      if ($urandom_range(0, 4) == 0 && x0 < W-1) begin
        x1 = x0;
        x0 = x0 + 1;
        make_bad = 1'b1;
      end
`endif
      run_req(x0, x1, y0, y1, int'($urandom_range(0, 3)), make_bad);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
